lsu_half: RTL
=============

# lsu_half

Load/store unit for halfword accesses (`lh`, `lhu`, `sh`) on the core side of the data-memory interface. It accepts one halfword operation from the execute stage and drives a word-wide, byte-enabled data-memory port using a request/grant plus read-valid handshake. An access at byte offset 3 crosses a word boundary, so the unit splits it into two byte accesses. It returns the sign- or zero-extended load result with a one-cycle `done` pulse, and the core stalls on `op_ready` until then.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk  in  1`  system clock; all state changes on its rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `op_valid  in  1`  the core presents an operation.
- `op_ready  out  1`  the unit accepts an operation; high only in IDLE.
- `op_store  in  1`  1 = `sh`, 0 = load.
- `op_unsigned  in  1`  load only: 1 = `lhu` (zero-extend), 0 = `lh` (sign-extend).
- `op_addr  in  32`  byte address; any alignment is legal.
- `op_wdata  in  32`  store data; only bits [15:0] are used.
- `done  out  1`  one-cycle pulse when the operation completes.
- `rdata  out  32`  extended load result; valid with `done` and held until the next load's `done`.
- `mem_req  out  1`  memory request; held high until granted.
- `mem_we  out  1`  1 = write.
- `mem_be  out  4`  byte enables.
- `mem_addr  out  32`  word-aligned address (bits [1:0] = 0).
- `mem_wdata  out  32`  write data, placed in byte lanes.
- `mem_gnt  in  1`  memory accepts the request this cycle.
- `mem_rvalid  in  1`  read data is valid this cycle.
- `mem_rdata  in  32`  read data word.

## Operation
- Capture rule: on `op_valid && op_ready`, capture `op_store`, `op_unsigned`, `op_addr`, and `op_wdata[15:0]`, then go to REQ. With `off = addr[1:0]` and `W = {addr[31:2],2'b00}`:
  - off 0: one access; be=0011; wdata = {16'b0,h}; result = rdata[15:0].
  - off 1: one access; be=0110; wdata = {8'b0,h,8'b0}; result = rdata[23:8].
  - off 2: one access; be=1100; wdata = {h,16'b0}; result = rdata[31:16].
  - off 3: two accesses.
    - Phase 0: word W, be=1000, wdata = {h[7:0],24'b0}; low byte = rdata[31:24].
    - Phase 1: word W+4 (mod 2^32), be=0001, wdata = {24'b0,h[15:8]}; high byte = rdata[7:0].
- For loads, `mem_wdata` = 0 and `mem_be` carries the same enables as for stores.
- States:
  - IDLE: `op_ready`=1, `mem_req`=0.
  - REQ: `mem_req`=1, and `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` are stable for the current phase. On `mem_gnt`:
    - store with more phases → REQ, next phase;
    - store, last phase → IDLE with `done`;
    - load → RESP.
  - RESP: wait for `mem_rvalid`, then capture the phase's byte(s). More phases → REQ, next phase. Last phase → IDLE with `done` and `rdata` updated.
- Result formation: assemble the halfword `{hi,lo}`. For `lh`, `rdata` = {{16{h[15]}},h}; for `lhu`, `rdata` = {16'b0,h}.
- Ignored inputs:
  - `mem_rvalid` in IDLE or REQ, including stale responses after a reset.
  - `mem_gnt` outside REQ.
  - `mem_rdata` unless `mem_rvalid` is high in RESP.
  - `op_valid` while busy; the core must hold the operation.
- Only one memory transaction is outstanding at a time. The unit issues no request while in RESP.

## Timing
- Reset values: state=IDLE, `op_ready`=1, `done`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation: the unit aborts and returns to IDLE on the next edge. No `done` is produced, and `rdata` is cleared to 0.
- Accept at edge k → `mem_req`=1 during cycle k+1.
- `mem_gnt` may assert in the first REQ cycle. There is no combinational path from `mem_gnt` or `mem_rvalid` to any output.
- Stores: `done` in the cycle after the last grant. An aligned store with immediate grant has accept at cycle 0, request/grant at cycle 1, `done` at cycle 2.
- Loads: `mem_rvalid` arrives at least one cycle after its grant. `done` and the new `rdata` appear in the cycle after the last `rvalid`.
- Off-3 operations: phase-1 `mem_req` rises in the cycle after the phase-0 grant (store) or the phase-0 `rvalid` (load).
- Back-to-back: `op_ready` is high in the same cycle as `done`, so a new operation can be accepted that cycle.

## Test plan
- **Aligned store:** `sh` with addr=0x100, wdata=0xDEADBEEF, `gnt` immediate → one request: `mem_addr`=0x100, be=0011, `mem_wdata`=0x0000BEEF, `done` at cycle 2.
- **Loads at offsets 1 and 2, with and without sign extension:**
  - `lh` at addr=0x101, `rdata` word 0x12F0AB34 returned 2 cycles after grant → be=0110, `rdata`=0xFFFFF0AB.
  - `lhu` at 0x102 on the same word → `rdata`=0x000012F0.
- **Split store:** `sh` at 0x103 with wdata=0x0000A55A → first request addr=0x100, be=1000, wdata=0x5A000000; second request addr=0x104, be=0001, wdata=0x000000A5; a single `done` pulse.
- **Split load with address wrap:** `lh` at 0xFFFFFFFF; word 0 returns 0x80000000 and word 1 returns 0x000000FF → addresses 0xFFFFFFFC then 0x00000000, `rdata`=0xFFFFFF80.
- **Grant stall:** hold `mem_gnt` low for 5 cycles → request signals stay stable, `op_ready`=0, and a second `op_valid` is ignored.
- **Reset mid-load:** assert `rst` while in RESP, then send a late `mem_rvalid` → `done` never pulses, `rdata`=0, and the next operation completes normally.

Source files
------------

// File: rtl/lsu_half.sv
// Halfword load/store unit: turns one lh/lhu/sh into one or two byte-enabled
// word accesses on a req/gnt + rvalid memory port and returns the extended result.
module lsu_half (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_store,
    input  logic        op_unsigned,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshakes: an op transfers on a rising edge with op_valid && op_ready;
    // a memory request transfers on a rising edge with mem_req && mem_gnt, and
    // the request fields stay constant from mem_req rising until that edge;
    // read data transfers on a rising edge with mem_rvalid while in RESP.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic        store_q, unsigned_q;
    logic [31:0] addr_q;
    logic [15:0] h_q;
    logic [7:0]  lo_q;
    logic        done_q, done_d;
    logic [31:0] rdata_q;

    logic        accept, lo_load, rdata_load;
    logic        last_phase;
    logic [31:0] word_addr;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    logic        unused_wdata_hi;
    assign unused_wdata_hi = ^op_wdata[31:16];

    // Only offset 3 straddles a word; it needs a second phase for the high byte.
    assign last_phase = (addr_q[1:0] != 2'b11) || phase_q;
    assign word_addr  = {addr_q[31:2], 2'b00} + (phase_q ? 32'd4 : 32'd0);

    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        load_half  = 16'h0;
        case (addr_q[1:0])
            2'd0: begin
                lane_be    = 4'b0011;
                lane_wdata = {16'h0, h_q};
                load_half  = mem_rdata[15:0];
            end
            2'd1: begin
                lane_be    = 4'b0110;
                lane_wdata = {8'h0, h_q, 8'h0};
                load_half  = mem_rdata[23:8];
            end
            2'd2: begin
                lane_be    = 4'b1100;
                lane_wdata = {h_q, 16'h0};
                load_half  = mem_rdata[31:16];
            end
            default: begin
                lane_be    = phase_q ? 4'b0001 : 4'b1000;
                lane_wdata = phase_q ? {24'h0, h_q[15:8]} : {h_q[7:0], 24'h0};
                load_half  = {mem_rdata[7:0], lo_q};
            end
        endcase
    end

    assign load_ext = unsigned_q ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        done_d     = 1'b0;
        accept     = 1'b0;
        lo_load    = 1'b0;
        rdata_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    accept  = 1'b1;
                    phase_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    if (!store_q) begin
                        state_d = S_RESP;
                    end else if (last_phase) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        phase_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    if (last_phase) begin
                        rdata_load = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        lo_load = 1'b1;
                        phase_d = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            h_q        <= 16'h0;
            lo_q       <= 8'h0;
            done_q     <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            if (accept) begin
                store_q    <= op_store;
                unsigned_q <= op_unsigned;
                addr_q     <= op_addr;
                h_q        <= op_wdata[15:0];
            end
            if (lo_load) begin
                lo_q <= mem_rdata[31:24];
            end
            if (rdata_load) begin
                rdata_q <= load_ext;
            end
        end
    end

    // Memory fields are forced to zero outside REQ so idle bus values are clean.
    assign op_ready  = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req & store_q;
    assign mem_be    = mem_req ? lane_be : 4'b0000;
    assign mem_addr  = mem_req ? word_addr : 32'h0;
    assign mem_wdata = (mem_req && store_q) ? lane_wdata : 32'h0;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule
